// File: rtl/regex_fetch_decode.sv
// -----------------------------------------------------------------------------
// regex_fetch_decode
//   Instruction fetch/decode stage of the regex engine core. Each accepted
//   fetch request (pc, current input char, thread tag) reads one 16-bit
//   instruction word {itype, data} from instruction memory. The word is decoded
//   on the following cycle and queued in a small in-order output buffer. The
//   thread execution/scheduling stage drains that buffer.
//
//   Latency: a request accepted in cycle N is read in cycle N. It is decoded
//   and pushed at the end of cycle N+1 and appears on out_valid in cycle N+2.
//
// Ports
//   clk, rst (sync, active high), flush  : clock / reset / drop all work
//   req_valid/req_ready, req_pc/char/tag : fetch request handshake
//   mem_rd_en, mem_addr, mem_rd_data     : instruction memory, 1-cycle read
//   out_valid/out_ready                  : decoded instruction handshake
//   out_itype/data/pc/tag                : raw word, request pc and tag
//   out_next0/next1/fork                 : successor pc(s)
//   out_accept/accept_part/kill/illegal  : decoded thread outcome flags
// -----------------------------------------------------------------------------
module regex_fetch_decode #(
   parameter int PC_WIDTH   = 9,
   parameter int CHAR_WIDTH = 8,
   parameter int TAG_WIDTH  = 4,
   parameter int FIFO_DEPTH = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [PC_WIDTH-1:0]   req_pc,
   input  logic [CHAR_WIDTH-1:0] req_char,
   input  logic [TAG_WIDTH-1:0]  req_tag,
   output logic                  mem_rd_en,
   output logic [PC_WIDTH-1:0]   mem_addr,
   input  logic [15:0]           mem_rd_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_itype,
   output logic [7:0]            out_data,
   output logic [PC_WIDTH-1:0]   out_pc,
   output logic [TAG_WIDTH-1:0]  out_tag,
   output logic [PC_WIDTH-1:0]   out_next0,
   output logic [PC_WIDTH-1:0]   out_next1,
   output logic                  out_fork,
   output logic                  out_accept,
   output logic                  out_accept_part,
   output logic                  out_kill,
   output logic                  out_illegal
);

   localparam int PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

   typedef struct packed {
      logic [7:0]           itype;
      logic [7:0]           data;
      logic [PC_WIDTH-1:0]  pc;
      logic [TAG_WIDTH-1:0] tag;
      logic [PC_WIDTH-1:0]  next0;
      logic [PC_WIDTH-1:0]  next1;
      logic                 is_fork;
      logic                 accept;
      logic                 accept_part;
      logic                 kill;
      logic                 illegal;
   } entry_t;

   // request held alongside the outstanding memory read
   logic                  inflight_reg;
   logic [PC_WIDTH-1:0]   pc_reg;
   logic [CHAR_WIDTH-1:0] char_reg;
   logic [TAG_WIDTH-1:0]  tag_reg;

   // output buffer
   entry_t               fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]     wptr_reg;
   logic [PTR_W-1:0]     rptr_reg;
   logic [CNT_W-1:0]     count_reg;

   logic                 accept;
   logic                 push;
   logic                 pop;
   logic [CNT_W:0]       used;
   entry_t               dec;
   entry_t               head;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Credit check counts the outstanding read as an occupied slot, so a push
   // can never find the buffer full. It depends only on registered state.
   assign used      = {1'b0, count_reg} + {{CNT_W{1'b0}}, inflight_reg};
   assign req_ready = !rst && !flush && (used < (CNT_W+1)'(FIFO_DEPTH));
   assign accept    = req_valid && req_ready;
   assign mem_rd_en = accept;
   assign mem_addr  = req_pc;

   assign push      = inflight_reg;
   assign out_valid = (count_reg != '0);
   assign pop       = out_valid && out_ready;

   // decode of the word returned for the in-flight request
   always_comb begin
      dec             = '0;
      dec.itype       = mem_rd_data[15:8];
      dec.data        = mem_rd_data[7:0];
      dec.pc          = pc_reg;
      dec.tag         = tag_reg;
      case (mem_rd_data[15:8])
         8'd0: begin                              // ACCEPT
            dec.accept = 1'b1;
            dec.next0  = pc_reg + PC_WIDTH'(1);
         end
         8'd1: begin                              // SPLIT
            dec.is_fork = 1'b1;
            dec.next0   = pc_reg + PC_WIDTH'(1);
            dec.next1   = PC_WIDTH'(mem_rd_data[7:0]);
         end
         8'd2: begin                              // MATCH
            dec.next0 = pc_reg + PC_WIDTH'(1);
            dec.kill  = (char_reg != CHAR_WIDTH'(mem_rd_data[7:0]));
         end
         8'd3: dec.next0 = PC_WIDTH'(mem_rd_data[7:0]);   // JMP
         8'd4: dec.kill  = 1'b1;                           // END_WITHOUT_ACCEPTING
         8'd5: dec.next0 = pc_reg + PC_WIDTH'(1);          // MATCH_ANY
         8'd6: begin                              // ACCEPT_PARTIAL
            dec.accept_part = 1'b1;
            dec.next0       = pc_reg + PC_WIDTH'(1);
         end
         default: begin
            dec.illegal = 1'b1;
            dec.kill    = 1'b1;
         end
      endcase
   end

   // control state: reset and flush discard both buffered and in-flight work
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         inflight_reg <= 1'b0;
         wptr_reg     <= '0;
         rptr_reg     <= '0;
         count_reg    <= '0;
      end else begin
         inflight_reg <= accept;
         if (push) wptr_reg <= ptr_inc(wptr_reg);
         if (pop)  rptr_reg <= ptr_inc(rptr_reg);
         case ({push, pop})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
         endcase
      end
   end

   // data path: no reset needed, qualified by the control state above
   always_ff @(posedge clk) begin
      if (accept) begin
         pc_reg   <= req_pc;
         char_reg <= req_char;
         tag_reg  <= req_tag;
      end
      if (push) fifo_mem[wptr_reg] <= dec;
   end

   // head entry only changes on pop, so outputs hold while stalled
   assign head            = fifo_mem[rptr_reg];
   assign out_itype       = head.itype;
   assign out_data        = head.data;
   assign out_pc          = head.pc;
   assign out_tag         = head.tag;
   assign out_next0       = head.next0;
   assign out_next1       = head.next1;
   assign out_fork        = head.is_fork;
   assign out_accept      = head.accept;
   assign out_accept_part = head.accept_part;
   assign out_kill        = head.kill;
   assign out_illegal     = head.illegal;

endmodule
